// File: rtl/axi_lite_rr_mux.sv
// -----------------------------------------------------------------------------
// axi_lite_rr_mux
//
// Shares one AXI4-Lite master port between NoSlvPorts AXI4-Lite requesters.
// The write path (AW/W/B) and the read path (AR/R) each run their own
// round-robin engine. Each engine allows one outstanding transaction.
// Responses return only to the port that issued the transaction.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous, active-high reset
//   slv_reqs_i   requests from the requester ports   [NoSlvPorts]
//   slv_resps_o  responses to the requester ports    [NoSlvPorts]
//   mst_req_o    request to the shared master port
//   mst_resp_i   response from the shared master port
//
// The package below supplies default AXI4-Lite channel structs (32-bit
// address and data). Other widths can be used through the type parameters,
// as long as the struct field names are the same.
// -----------------------------------------------------------------------------
package axi_lite_rr_mux_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } ax_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } w_chan_t;

   typedef struct packed {
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_lite_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      logic    ar_ready;
      r_chan_t r;
      logic    r_valid;
   } resp_lite_t;

endpackage

module axi_lite_rr_mux #(
   parameter int unsigned NoSlvPorts  = 2,
   parameter type         req_lite_t  = axi_lite_rr_mux_pkg::req_lite_t,
   parameter type         resp_lite_t = axi_lite_rr_mux_pkg::resp_lite_t
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  req_lite_t  slv_reqs_i  [NoSlvPorts],
   output resp_lite_t slv_resps_o [NoSlvPorts],
   output req_lite_t  mst_req_o,
   input  resp_lite_t mst_resp_i
);

   localparam int unsigned SelW = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1;

   typedef logic [SelW-1:0] sel_t;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_e;

   // Picks the first requesting port, scanning from prio upwards and wrapping.
   function automatic sel_t rr_pick(input logic [NoSlvPorts-1:0] req, input sel_t prio);
      sel_t        pick;
      logic        found;
      int unsigned idx;
      pick  = prio;
      found = 1'b0;
      for (int unsigned k = 0; k < NoSlvPorts; k++) begin
         idx = (32'(prio) + k) % NoSlvPorts;
         if (!found && req[idx]) begin
            pick  = sel_t'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // After a port is served it gets the lowest priority.
   function automatic sel_t rr_next(input sel_t sel);
      return sel_t'((32'(sel) + 1) % NoSlvPorts);
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   w_state_e w_state_q, w_state_d;
   sel_t     w_sel_q,   w_sel_d;
   sel_t     w_prio_q,  w_prio_d;
   logic     aw_done_q, aw_done_d;
   logic     w_done_q,  w_done_d;

   r_state_e r_state_q, r_state_d;
   sel_t     r_sel_q,   r_sel_d;
   sel_t     r_prio_q,  r_prio_d;

   logic [NoSlvPorts-1:0] aw_valids;
   logic [NoSlvPorts-1:0] ar_valids;

   // Arbitration looks at aw_valid / ar_valid only. A W that arrives early
   // waits at its requester until its AW has been granted.
   for (genvar i = 0; i < NoSlvPorts; i++) begin : g_valids
      assign aw_valids[i] = slv_reqs_i[i].aw_valid;
      assign ar_valids[i] = slv_reqs_i[i].ar_valid;
   end

   // ---------------------------------------------------------------------------
   // Datapath and handshake routing
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output gets a default before the state-dependent overrides.
      // That way each path assigns a value, and no latch is inferred.
      mst_req_o    = '0;
      mst_req_o.aw = slv_reqs_i[w_sel_q].aw;
      mst_req_o.w  = slv_reqs_i[w_sel_q].w;
      mst_req_o.ar = slv_reqs_i[r_sel_q].ar;

      // Response payloads go to every port. Only the valid bits are steered.
      for (int i = 0; i < NoSlvPorts; i++) begin
         slv_resps_o[i]   = '0;
         slv_resps_o[i].b = mst_resp_i.b;
         slv_resps_o[i].r = mst_resp_i.r;
      end

      if (w_state_q == W_ADDR) begin
         // A channel that has already handshaken is masked. This stops a
         // requester that is presenting its next beat from being accepted twice.
         mst_req_o.aw_valid = slv_reqs_i[w_sel_q].aw_valid & ~aw_done_q;
         mst_req_o.w_valid  = slv_reqs_i[w_sel_q].w_valid  & ~w_done_q;
         slv_resps_o[w_sel_q].aw_ready = mst_resp_i.aw_ready & ~aw_done_q;
         slv_resps_o[w_sel_q].w_ready  = mst_resp_i.w_ready  & ~w_done_q;
      end

      if (w_state_q == W_RESP) begin
         mst_req_o.b_ready            = slv_reqs_i[w_sel_q].b_ready;
         slv_resps_o[w_sel_q].b_valid = mst_resp_i.b_valid;
      end

      if (r_state_q == R_ADDR) begin
         mst_req_o.ar_valid            = slv_reqs_i[r_sel_q].ar_valid;
         slv_resps_o[r_sel_q].ar_ready = mst_resp_i.ar_ready;
      end

      if (r_state_q == R_RESP) begin
         mst_req_o.r_ready            = slv_reqs_i[r_sel_q].r_ready;
         slv_resps_o[r_sel_q].r_valid = mst_resp_i.r_valid;
      end
   end

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign aw_hs = mst_req_o.aw_valid & mst_resp_i.aw_ready;
   assign w_hs  = mst_req_o.w_valid  & mst_resp_i.w_ready;
   assign b_hs  = mst_resp_i.b_valid & mst_req_o.b_ready;
   assign ar_hs = mst_req_o.ar_valid & mst_resp_i.ar_ready;
   assign r_hs  = mst_resp_i.r_valid & mst_req_o.r_ready;

   // ---------------------------------------------------------------------------
   // Write engine next state
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_d = w_state_q;
      w_sel_d   = w_sel_q;
      w_prio_d  = w_prio_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      unique case (w_state_q)
         W_IDLE: begin
            if (|aw_valids) begin
               w_sel_d   = rr_pick(aw_valids, w_prio_q);
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               w_state_d = W_ADDR;
            end
         end
         W_ADDR: begin
            // AW and W may complete in the same cycle or in any order.
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q  | w_hs;
            if (aw_done_d && w_done_d) w_state_d = W_RESP;
         end
         W_RESP: begin
            if (b_hs) begin
               w_prio_d  = rr_next(w_sel_q);
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Read engine next state
   // ---------------------------------------------------------------------------
   always_comb begin
      r_state_d = r_state_q;
      r_sel_d   = r_sel_q;
      r_prio_d  = r_prio_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (|ar_valids) begin
               r_sel_d   = rr_pick(ar_valids, r_prio_q);
               r_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            if (ar_hs) r_state_d = R_RESP;
         end
         R_RESP: begin
            if (r_hs) begin
               r_prio_d  = rr_next(r_sel_q);
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments here, so every register samples the
      // values from before the clock edge no matter what order the lines are in.
      if (rst_i) begin
         w_state_q <= W_IDLE;
         w_sel_q   <= '0;
         w_prio_q  <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         r_state_q <= R_IDLE;
         r_sel_q   <= '0;
         r_prio_q  <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_sel_q   <= w_sel_d;
         w_prio_q  <= w_prio_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         r_state_q <= r_state_d;
         r_sel_q   <= r_sel_d;
         r_prio_q  <= r_prio_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_rr_mux.sv
// -----------------------------------------------------------------------------
// Testbench for axi_lite_rr_mux with two requester ports.
// A per-cycle vector table covers the write engine: single write, contention,
// W before AW and split handshakes. Hand-written sequences cover concurrent
// read/write and reset in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_axi_lite_rr_mux;
   import axi_lite_rr_mux_pkg::*;

   localparam logic [31:0] A0 = 32'h0000_0100;
   localparam logic [31:0] D0 = 32'hDEAD_BEEF;
   localparam logic [31:0] A1 = 32'h0000_0300;
   localparam logic [31:0] D1 = 32'h0000_0055;
   localparam logic [31:0] R0 = 32'h0000_0200;
   localparam logic [31:0] R1 = 32'h0000_0400;

   logic       clk;
   logic       rst;
   req_lite_t  slv_reqs  [2];
   resp_lite_t slv_resps [2];
   req_lite_t  mst_req;
   resp_lite_t mst_resp;

   int n_checks = 0;
   int n_errors = 0;

   axi_lite_rr_mux #(.NoSlvPorts(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .slv_reqs_i  (slv_reqs),
      .slv_resps_o (slv_resps),
      .mst_req_o   (mst_req),
      .mst_resp_i  (mst_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One record per cycle. Slave bits are {aw_ready, w_ready, b_valid}.
   typedef struct {
      logic        rst;
      logic [1:0]  awv, wv, brdy;
      logic [2:0]  slv;
      logic [4:0]  e_mst;  // {aw_valid, w_valid, b_ready, ar_valid, r_ready}
      logic [5:0]  e_rdy;  // {aw_ready[1:0], w_ready[1:0], ar_ready[1:0]}
      logic [3:0]  e_vld;  // {b_valid[1:0], r_valid[1:0]}
      logic [31:0] e_awaddr;
      logic [31:0] e_wdata;
   } vec_t;

   function automatic vec_t row(input logic r, input logic [1:0] awv, input logic [1:0] wv,
                                input logic [1:0] brdy, input logic [2:0] slv,
                                input logic [4:0] e_mst, input logic [5:0] e_rdy,
                                input logic [3:0] e_vld, input logic [31:0] e_awaddr,
                                input logic [31:0] e_wdata);
      vec_t v;
      v.rst = r; v.awv = awv; v.wv = wv; v.brdy = brdy; v.slv = slv;
      v.e_mst = e_mst; v.e_rdy = e_rdy; v.e_vld = e_vld;
      v.e_awaddr = e_awaddr; v.e_wdata = e_wdata;
      return v;
   endfunction

   function automatic logic [4:0] mst_bits();
      return {mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready, mst_req.ar_valid, mst_req.r_ready};
   endfunction

   function automatic logic [5:0] rdy_bits();
      return {slv_resps[1].aw_ready, slv_resps[0].aw_ready, slv_resps[1].w_ready,
              slv_resps[0].w_ready, slv_resps[1].ar_ready, slv_resps[0].ar_ready};
   endfunction

   function automatic logic [3:0] vld_bits();
      return {slv_resps[1].b_valid, slv_resps[0].b_valid, slv_resps[1].r_valid, slv_resps[0].r_valid};
   endfunction

   task automatic clear_handshakes();
      for (int i = 0; i < 2; i++) begin
         slv_reqs[i].aw_valid = 1'b0;
         slv_reqs[i].w_valid  = 1'b0;
         slv_reqs[i].b_ready  = 1'b0;
         slv_reqs[i].ar_valid = 1'b0;
         slv_reqs[i].r_ready  = 1'b0;
      end
      mst_resp = '0;
   endtask

   vec_t tbl[$];

   initial begin
      // Fixed payloads per port.
      slv_reqs[0] = '0;
      slv_reqs[1] = '0;
      slv_reqs[0].aw.addr = A0; slv_reqs[0].w.data = D0; slv_reqs[0].w.strb = 4'hF;
      slv_reqs[1].aw.addr = A1; slv_reqs[1].w.data = D1; slv_reqs[1].w.strb = 4'h1;
      slv_reqs[0].ar.addr = R0; slv_reqs[1].ar.addr = R1;
      clear_handshakes();

      // Reset state.
      tbl.push_back(row(0, 2'b00, 2'b00, 2'b00, 3'b000, 5'b00000, 6'b000000, 4'b0000, A0, D0));
      // Single write, port 0, slave ready at once.
      tbl.push_back(row(0, 2'b01, 2'b01, 2'b01, 3'b110, 5'b00000, 6'b000000, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b01, 2'b01, 2'b01, 3'b110, 5'b11000, 6'b010100, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b00, 2'b00, 2'b01, 3'b001, 5'b00100, 6'b000000, 4'b0100, A0, D0));
      tbl.push_back(row(0, 2'b00, 2'b00, 2'b00, 3'b000, 5'b00000, 6'b000000, 4'b0000, A0, D0));
      // Reset, then contention: grants 0, 1, 0, 1.
      tbl.push_back(row(1, 2'b00, 2'b00, 2'b00, 3'b000, 5'b00000, 6'b000000, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b110, 5'b00000, 6'b000000, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b110, 5'b11000, 6'b010100, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b111, 5'b00100, 6'b000000, 4'b0100, A0, D0));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b110, 5'b00000, 6'b000000, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b110, 5'b11000, 6'b101000, 4'b0000, A1, D1));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b111, 5'b00100, 6'b000000, 4'b1000, A1, D1));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b110, 5'b00000, 6'b000000, 4'b0000, A1, D1));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b110, 5'b11000, 6'b010100, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b111, 5'b00100, 6'b000000, 4'b0100, A0, D0));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b110, 5'b00000, 6'b000000, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b110, 5'b11000, 6'b101000, 4'b0000, A1, D1));
      tbl.push_back(row(0, 2'b11, 2'b11, 2'b11, 3'b111, 5'b00100, 6'b000000, 4'b1000, A1, D1));
      tbl.push_back(row(0, 2'b00, 2'b00, 2'b00, 3'b000, 5'b00000, 6'b000000, 4'b0000, A1, D1));
      // W before AW on port 1.
      tbl.push_back(row(0, 2'b00, 2'b10, 2'b00, 3'b110, 5'b00000, 6'b000000, 4'b0000, A1, D1));
      tbl.push_back(row(0, 2'b00, 2'b10, 2'b00, 3'b110, 5'b00000, 6'b000000, 4'b0000, A1, D1));
      tbl.push_back(row(0, 2'b10, 2'b10, 2'b10, 3'b110, 5'b00000, 6'b000000, 4'b0000, A1, D1));
      tbl.push_back(row(0, 2'b10, 2'b10, 2'b10, 3'b110, 5'b11000, 6'b101000, 4'b0000, A1, D1));
      tbl.push_back(row(0, 2'b00, 2'b00, 2'b10, 3'b001, 5'b00100, 6'b000000, 4'b1000, A1, D1));
      // Split handshakes on port 0: W in cycle 1, AW in cycle 3.
      tbl.push_back(row(0, 2'b01, 2'b01, 2'b01, 3'b000, 5'b00000, 6'b000000, 4'b0000, A1, D1));
      tbl.push_back(row(0, 2'b01, 2'b01, 2'b01, 3'b010, 5'b11000, 6'b000100, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b01, 2'b01, 2'b01, 3'b010, 5'b10000, 6'b000000, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b01, 2'b01, 2'b01, 3'b110, 5'b10000, 6'b010000, 4'b0000, A0, D0));
      tbl.push_back(row(0, 2'b00, 2'b00, 2'b01, 3'b001, 5'b00100, 6'b000000, 4'b0100, A0, D0));
      tbl.push_back(row(0, 2'b00, 2'b00, 2'b00, 3'b000, 5'b00000, 6'b000000, 4'b0000, A0, D0));

      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);

      for (int k = 0; k < tbl.size(); k++) begin
         rst = tbl[k].rst;
         for (int p = 0; p < 2; p++) begin
            slv_reqs[p].aw_valid = tbl[k].awv[p];
            slv_reqs[p].w_valid  = tbl[k].wv[p];
            slv_reqs[p].b_ready  = tbl[k].brdy[p];
         end
         mst_resp.aw_ready = tbl[k].slv[2];
         mst_resp.w_ready  = tbl[k].slv[1];
         mst_resp.b_valid  = tbl[k].slv[0];
         #1;
         if (!tbl[k].rst) begin
            check($sformatf("row%0d_mst_valid", k), 32'(mst_bits()), 32'(tbl[k].e_mst));
            check($sformatf("row%0d_slv_ready", k), 32'(rdy_bits()), 32'(tbl[k].e_rdy));
            check($sformatf("row%0d_slv_valid", k), 32'(vld_bits()), 32'(tbl[k].e_vld));
            check($sformatf("row%0d_aw_addr", k), mst_req.aw.addr, tbl[k].e_awaddr);
            check($sformatf("row%0d_w_data", k), mst_req.w.data, tbl[k].e_wdata);
         end
         @(negedge clk);
      end

      // ---- Concurrent read (port 0) and write (port 1) ----
      clear_handshakes();
      slv_reqs[0].ar_valid = 1'b1; slv_reqs[0].r_ready = 1'b1;
      slv_reqs[1].aw_valid = 1'b1; slv_reqs[1].w_valid = 1'b1; slv_reqs[1].b_ready = 1'b1;
      mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1; mst_resp.ar_ready = 1'b1;
      #1;
      check("conc_idle_no_valid", 32'(mst_bits()), 32'h0);
      @(negedge clk); #1;
      check("conc_mst_valid", 32'(mst_bits()), 32'b11010);
      check("conc_slv_ready", 32'(rdy_bits()), 32'b101001);
      check("conc_aw_addr", mst_req.aw.addr, A1);
      check("conc_ar_addr", mst_req.ar.addr, R0);
      @(negedge clk);
      slv_reqs[0].ar_valid = 1'b0;
      slv_reqs[1].aw_valid = 1'b0; slv_reqs[1].w_valid = 1'b0;
      mst_resp.b_valid = 1'b1; mst_resp.b.resp = 2'b00;
      mst_resp.r_valid = 1'b1; mst_resp.r.data = 32'h1234_5678; mst_resp.r.resp = 2'b10;
      #1;
      check("conc_resp_valid", 32'(vld_bits()), 32'b1001);
      check("conc_mst_ready", 32'(mst_bits()), 32'b00101);
      check("conc_r_data", slv_resps[0].r.data, 32'h1234_5678);
      check("conc_r_resp", 32'(slv_resps[0].r.resp), 32'h2);
      check("conc_b_resp", 32'(slv_resps[1].b.resp), 32'h0);
      // Slave keeps valids high while both engines are idle again: not forwarded.
      @(negedge clk); #1;
      check("idle_resp_blocked", 32'(vld_bits()), 32'h0);
      check("idle_mst_ready", 32'(mst_bits()), 32'h0);

      // ---- Reset while the write engine waits in W_RESP ----
      @(negedge clk);
      clear_handshakes();
      slv_reqs[0].aw_valid = 1'b1; slv_reqs[0].w_valid = 1'b1; slv_reqs[0].b_ready = 1'b1;
      mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
      @(negedge clk); #1;
      check("rst_seq_addr", 32'(mst_bits()), 32'b11000);
      @(negedge clk);
      slv_reqs[0].aw_valid = 1'b0; slv_reqs[0].w_valid = 1'b0;
      #1;
      check("rst_seq_in_resp", 32'(mst_bits()), 32'b00100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mst_resp.b_valid = 1'b1;
      #1;
      check("post_reset_mst", 32'(mst_bits()), 32'h0);
      check("post_reset_rdy", 32'(rdy_bits()), 32'h0);
      check("post_reset_vld", 32'(vld_bits()), 32'h0);
      @(negedge clk);
      clear_handshakes();
      slv_reqs[1].aw_valid = 1'b1; slv_reqs[1].w_valid = 1'b1; slv_reqs[1].b_ready = 1'b1;
      slv_reqs[0].ar_valid = 1'b1; slv_reqs[1].ar_valid = 1'b1;
      slv_reqs[0].r_ready  = 1'b1; slv_reqs[1].r_ready  = 1'b1;
      mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1; mst_resp.ar_ready = 1'b1;
      #1;
      check("post_reset_idle", 32'(mst_bits()), 32'h0);
      @(negedge clk); #1;
      // Read pointer was 1 before reset; port 0 winning shows it returned to 0.
      check("post_reset_grant_mst", 32'(mst_bits()), 32'b11010);
      check("post_reset_grant_rdy", 32'(rdy_bits()), 32'b101001);
      check("post_reset_aw_addr", mst_req.aw.addr, A1);
      check("post_reset_ar_addr", mst_req.ar.addr, R0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         slv_reqs[i].aw_valid = 1'b0; slv_reqs[i].w_valid = 1'b0; slv_reqs[i].ar_valid = 1'b0;
      end
      mst_resp.b_valid = 1'b1; mst_resp.r_valid = 1'b1;
      #1;
      check("post_reset_resp", 32'(vld_bits()), 32'b1001);
      @(negedge clk);
      clear_handshakes();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
